msbs_t3_coef_sim2seq_unload: RTL and testbench

//  Consumer-side end of the t=3 mSBS coefficient bus. Captures the simultaneous bus of

---
 rtl/msbs_t3_coef_sim2seq_unload.sv | 175 +++++++++++++++++
 tb/tb_msbs_t3_coef_sim2seq_unload.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/msbs_t3_coef_sim2seq_unload.sv
// t=3 mSBS coefficient unloader: captures a full batch of slots in one load and streams them one per beat.
// Optional build macro MSBS_T3_UNLOAD_SKIP_DEG1_EN skips slots whose deg2 and deg3 flags are both clear.
module msbs_t3_coef_sim2seq_unload #(
  parameter int GF_LEN             = 10,
  parameter int TEST_PATTEN_NUMS   = 8,
  parameter int EQUATION_COEF_NUMS = 4,
  parameter int DIRECTION          = 1
) (
  input  logic clk,
  input  logic in_ctr_Srst,
  input  logic in_ctr_en,
  input  logic in_load_valid,
  output logic out_load_ready,
  input  logic [TEST_PATTEN_NUMS*EQUATION_COEF_NUMS*GF_LEN-1:0] in_coef,
  input  logic [TEST_PATTEN_NUMS-1:0] in_tp_deg2,
  input  logic [TEST_PATTEN_NUMS-1:0] in_tp_deg3,
  output logic out_valid,
  input  logic in_ready,
  output logic [EQUATION_COEF_NUMS*GF_LEN-1:0] out_coef,
  output logic out_deg2,
  output logic out_deg3,
  output logic [$clog2(TEST_PATTEN_NUMS)-1:0] out_tp_idx,
  output logic out_last,
  output logic out_done
);

  localparam int TP = TEST_PATTEN_NUMS;
  localparam int CW = EQUATION_COEF_NUMS * GF_LEN;
  localparam int IW = $clog2(TP);
  localparam bit UP = (DIRECTION != 0);
  localparam logic [IW-1:0] IDX_FIRST = UP ? '0 : IW'(TP - 1);
  localparam logic [IW-1:0] IDX_LAST  = UP ? IW'(TP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [TP*CW-1:0] r_coef;
  logic [TP-1:0]    r_deg2;
  logic [TP-1:0]    r_deg3;
  logic [IW-1:0]    r_idx;

  logic          w_load_rdy;
  logic          w_load;
  logic          w_beat;
  logic          w_last;
  logic          w_valid;
  logic          w_first_ok;
  logic [IW-1:0] w_first_idx;
  logic [IW-1:0] w_next_idx;

`ifdef MSBS_T3_UNLOAD_SKIP_DEG1_EN
  logic [TP-1:0] w_in_qual;
  logic [TP-1:0] w_qual;
  logic          w_next_ok;

  // Find first qualifying slot of the incoming batch and next qualifying slot after r_idx.
  always_comb begin
    w_in_qual   = in_tp_deg2 | in_tp_deg3;
    w_qual      = r_deg2 | r_deg3;
    w_first_ok  = |w_in_qual;
    w_first_idx = IDX_FIRST;
    w_next_ok   = 1'b0;
    w_next_idx  = r_idx;
    if (UP) begin
      for (int k = TP - 1; k >= 0; k--) begin
        if (w_in_qual[k]) begin
          w_first_idx = IW'(k);
        end
        if (w_qual[k] && (IW'(k) > r_idx)) begin
          w_next_ok  = 1'b1;
          w_next_idx = IW'(k);
        end
      end
    end else begin
      for (int k = 0; k < TP; k++) begin
        if (w_in_qual[k]) begin
          w_first_idx = IW'(k);
        end
        if (w_qual[k] && (IW'(k) < r_idx)) begin
          w_next_ok  = 1'b1;
          w_next_idx = IW'(k);
        end
      end
    end
    w_last = !w_next_ok;
  end
`else
  // Every slot is emitted: step by one, stop at the terminal slot.
  always_comb begin
    w_first_ok  = 1'b1;
    w_first_idx = IDX_FIRST;
    w_next_idx  = UP ? (r_idx + 1'b1) : (r_idx - 1'b1);
    w_last      = (r_idx == IDX_LAST);
  end
`endif

  // Handshake qualification and next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_load_rdy  = (r_state == S_IDLE) && in_ctr_en;
    w_load      = w_load_rdy && in_load_valid;
    w_beat      = (r_state == S_STREAM) && in_ready && in_ctr_en;
    unique case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_state_nxt = w_first_ok ? S_STREAM : S_DONE;
        end
      end
      S_STREAM: begin
        if (w_beat && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; enable low freezes it, reset wins.
  always_ff @(posedge clk) begin
    if (in_ctr_Srst) begin
      r_state <= S_IDLE;
    end else if (in_ctr_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Shadow copy of the batch and the current slot pointer.
  always_ff @(posedge clk) begin
    if (in_ctr_Srst) begin
      r_coef <= '0;
      r_deg2 <= '0;
      r_deg3 <= '0;
      r_idx  <= '0;
    end else if (w_load) begin
      r_coef <= in_coef;
      r_deg2 <= in_tp_deg2;
      r_deg3 <= in_tp_deg3;
      r_idx  <= w_first_idx;
    end else if (w_beat && !w_last) begin
      r_idx  <= w_next_idx;
    end
  end

  // Output mux of registered state; everything zero while not valid.
  always_comb begin
    w_valid        = (r_state == S_STREAM);
    out_load_ready = w_load_rdy;
    out_valid      = w_valid;
    out_done       = (r_state == S_DONE);
    out_coef       = '0;
    out_deg2       = 1'b0;
    out_deg3       = 1'b0;
    out_tp_idx     = '0;
    out_last       = 1'b0;
    if (w_valid) begin
      out_coef   = r_coef[int'(r_idx)*CW +: CW];
      out_deg2   = r_deg2[r_idx];
      out_deg3   = r_deg3[r_idx];
      out_tp_idx = r_idx;
      out_last   = w_last;
    end
  end

endmodule

// File: tb/tb_msbs_t3_coef_sim2seq_unload.sv
// Directed bench for msbs_t3_coef_sim2seq_unload.
// Two instances (ascending and descending order) share all inputs.
module tb_msbs_t3_coef_sim2seq_unload;

  logic         clk;
  logic         srst;
  logic         en;
  logic         lv;
  logic         ready;
  logic [319:0] coef;
  logic [7:0]   d2;
  logic [7:0]   d3;

  logic        lr1, v1, od2_1, od3_1, last1, done1;
  logic [39:0] oc1;
  logic [2:0]  ix1;
  logic        lr0, v0, od2_0, od3_0, last0, done0;
  logic [39:0] oc0;
  logic [2:0]  ix0;

  int nvec = 0;
  int nfail = 0;

  localparam logic [7:0]  FA   = 8'b1010_1010;
  localparam logic [7:0]  FB   = 8'b0101_0101;
  localparam logic [23:0] S_UP = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] S_DN = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  msbs_t3_coef_sim2seq_unload #(
    .GF_LEN(10), .TEST_PATTEN_NUMS(8), .EQUATION_COEF_NUMS(4), .DIRECTION(1)
  ) dut1 (
    .clk(clk), .in_ctr_Srst(srst), .in_ctr_en(en),
    .in_load_valid(lv), .out_load_ready(lr1),
    .in_coef(coef), .in_tp_deg2(d2), .in_tp_deg3(d3),
    .out_valid(v1), .in_ready(ready), .out_coef(oc1),
    .out_deg2(od2_1), .out_deg3(od3_1), .out_tp_idx(ix1),
    .out_last(last1), .out_done(done1)
  );

  msbs_t3_coef_sim2seq_unload #(
    .GF_LEN(10), .TEST_PATTEN_NUMS(8), .EQUATION_COEF_NUMS(4), .DIRECTION(0)
  ) dut0 (
    .clk(clk), .in_ctr_Srst(srst), .in_ctr_en(en),
    .in_load_valid(lv), .out_load_ready(lr0),
    .in_coef(coef), .in_tp_deg2(d2), .in_tp_deg3(d3),
    .out_valid(v0), .in_ready(ready), .out_coef(oc0),
    .out_deg2(od2_0), .out_deg3(od3_0), .out_tp_idx(ix0),
    .out_last(last0), .out_done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] ecoef(input int base, input int k);
    return {10'(base + k), 10'(base + k + 16),
            10'(base + k + 32), 10'(base + k + 48)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    nvec++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coef(input int base);
    for (int k = 0; k < 8; k++) coef[k*40 +: 40] = ecoef(base, k);
  endtask

  task automatic load(input int base, input logic [7:0] f2,
                      input logic [7:0] f3);
    set_coef(base);
    d2 = f2;
    d3 = f3;
    lv = 1'b1;
    #1;
    chk("load_rdy", 64'(lr1), 64'd1);
    cyc();
    lv = 1'b0;
  endtask

  task automatic run(input string tag, input int base,
                     input logic [7:0] f2, input logic [7:0] f3,
                     input int n, input logic [23:0] s1,
                     input logic [23:0] s0, input bit tog);
    int nb;
    logic [2:0] k1;
    logic [2:0] k0;
    nb = 0;
    for (int c = 0; c < 60 && !done1; c++) begin
      ready = tog ? (c % 2 == 0) : 1'b1;
      #1;
      if (v1 && nb < 8) begin
        k1 = s1[nb*3 +: 3];
        k0 = s0[nb*3 +: 3];
        chk({tag, "_idx1"}, 64'(ix1), 64'(k1));
        chk({tag, "_coef1"}, 64'(oc1), 64'(ecoef(base, int'(k1))));
        chk({tag, "_deg2"}, 64'(od2_1), 64'(f2[k1]));
        chk({tag, "_deg3"}, 64'(od3_1), 64'(f3[k1]));
        chk({tag, "_last1"}, 64'(last1), 64'(nb == n - 1));
        chk({tag, "_v0"}, 64'(v0), 64'd1);
        chk({tag, "_idx0"}, 64'(ix0), 64'(k0));
        chk({tag, "_coef0"}, 64'(oc0), 64'(ecoef(base, int'(k0))));
        chk({tag, "_last0"}, 64'(last0), 64'(nb == n - 1));
        if (ready) nb++;
      end
      cyc();
    end
    ready = 1'b0;
    #1;
    chk({tag, "_done1"}, 64'(done1), 64'd1);
    chk({tag, "_done0"}, 64'(done0), 64'd1);
    chk({tag, "_beats"}, 64'(nb), 64'(n));
    chk({tag, "_dn_v"}, 64'(v1), 64'd0);
    chk({tag, "_dn_coef"}, 64'(oc1), 64'd0);
    chk({tag, "_dn_rdy"}, 64'(lr1), 64'd0);
    cyc();
    chk({tag, "_idle_rdy"}, 64'(lr1), 64'd1);
    chk({tag, "_idle_done"}, 64'(done1), 64'd0);
  endtask

  initial begin
    srst = 1'b1;
    en = 1'b1;
    lv = 1'b0;
    ready = 1'b0;
    coef = '0;
    d2 = '0;
    d3 = '0;
    cyc();
    cyc();
    srst = 1'b0;
    #1;
    chk("rst_valid", 64'(v1), 64'd0);
    chk("rst_done", 64'(done1), 64'd0);
    chk("rst_coef", 64'(oc1), 64'd0);
    chk("rst_idx", 64'(ix1), 64'd0);
    chk("rst_last", 64'(last1), 64'd0);
    chk("rst_rdy", 64'(lr1), 64'd1);
    chk("rst_rdy0", 64'(lr0), 64'd1);
    en = 1'b0;
    #1;
    chk("rst_rdy_en0", 64'(lr1), 64'd0);
    en = 1'b1;
    cyc();

    // ascending/descending, ready held high
    load(0, FA, FB);
    run("t1", 0, FA, FB, 8, S_UP, S_DN, 1'b0);

    // ready toggling 1,0
    load(0, FA, FB);
    run("t2", 0, FA, FB, 8, S_UP, S_DN, 1'b1);

    // enable low for 3 cycles at idx 3
    load(0, FA, FB);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_pre_idx", 64'(ix1), 64'(i));
      cyc();
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_hold_idx", 64'(ix1), 64'd3);
      chk("t3_hold_v", 64'(v1), 64'd1);
      chk("t3_hold_coef", 64'(oc1), 64'(ecoef(0, 3)));
      chk("t3_hold_idx0", 64'(ix0), 64'd4);
      cyc();
    end
    en = 1'b1;
    run("t3", 0, FA, FB, 5, S_UP >> 9, S_DN >> 9, 1'b0);

    // reset pulse at idx 5
    load(0, FA, FB);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_pre_idx", 64'(ix1), 64'(i));
      cyc();
    end
    #1;
    chk("t4_at5", 64'(ix1), 64'd5);
    srst = 1'b1;
    cyc();
    srst = 1'b0;
    ready = 1'b0;
    #1;
    chk("t4_rst_v", 64'(v1), 64'd0);
    chk("t4_rst_done", 64'(done1), 64'd0);
    chk("t4_rst_rdy", 64'(lr1), 64'd1);
    chk("t4_rst_coef", 64'(oc1), 64'd0);
    cyc();
    chk("t4_rst_done2", 64'(done1), 64'd0);
    load(100, FB, FA);
    run("t4", 100, FB, FA, 8, S_UP, S_DN, 1'b0);

    // input bus changes after accept
    load(200, FA, FB);
    set_coef(300);
    d2 = ~FA;
    d3 = ~FB;
    run("t5", 200, FA, FB, 8, S_UP, S_DN, 1'b0);

    // sparse and empty flag patterns
`ifdef MSBS_T3_UNLOAD_SKIP_DEG1_EN
    load(40, 8'b0010_0100, 8'h00);
    run("t6", 40, 8'b0010_0100, 8'h00, 2,
        24'({3'd5, 3'd2}), 24'({3'd2, 3'd5}), 1'b0);
    load(40, 8'h00, 8'h00);
    run("t6z", 40, 8'h00, 8'h00, 0, 24'd0, 24'd0, 1'b0);
`else
    load(40, 8'b0010_0100, 8'h00);
    run("t6", 40, 8'b0010_0100, 8'h00, 8, S_UP, S_DN, 1'b0);
    load(40, 8'h00, 8'h00);
    run("t6z", 40, 8'h00, 8'h00, 8, S_UP, S_DN, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
